note_sine_gen: RTL and testbench
================================

Name: note_sine_gen

Overview:
Tone-generation stage directly downstream of the keyboard decoder and the debounce/one-shot block. It takes the 6-bit note index plus one-shot note-on/note-off strobes and produces an 8-bit offset-binary sine sample stream at a fixed sample rate, suitable for a PWM/DAC output stage. It uses a phase accumulator, a per-note phase-increment ROM and a quarter-wave sine LUT. A small FSM lets the current waveform finish its cycle on release, so the output stops at mid-scale without a click.

Parameters:
CLK_HZ, 10_000_000, system clock frequency in Hz; used only to derive the increment ROM
SAMPLE_DIV, 256, clocks per sample tick; default sample rate is 39062.5 Hz
PHASE_W, 16, phase accumulator width in bits; must be at least 8

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
NOTE  input  6  note index from the decoder; 0 = C2 (65.406 Hz), 33 = A4 (440 Hz), 47 = B5; values 48..63 are invalid
NOTE_ON  input  1  one-cycle strobe from the one-shot: start or retrigger NOTE
NOTE_OFF  input  1  one-cycle strobe: release the current note
SAMPLE  output  8  offset-binary sine sample; 128 = zero
SAMPLE_VALID  output  1  one-cycle pulse, high in the cycle SAMPLE updates
ACTIVE  output  1  high while in PLAY or RELEASE

Behaviour:
- Reset (async, RST_N=0) sets: tick counter 0, phase 0, inc 0, state IDLE, SAMPLE=128, SAMPLE_VALID=0, ACTIVE=0.
- Tick counter: free-running 0..SAMPLE_DIV-1. A tick occurs in the cycle the counter equals SAMPLE_DIV-1. Note events never reset the counter.
- Increment ROM: inc(n) = round(440 * 2^((n-33)/12) * 2^PHASE_W * SAMPLE_DIV / CLK_HZ). Required default values: inc(0)=110, inc(33)=738, inc(47)=1657.
- Sine mapping: p = phase[PHASE_W-1 -: 8]; q = p[7:6]; i = p[5:0].
  - Quarter-wave LUT: L[k] = round(127 * sin(pi/2 * (k+0.5)/64)), k = 0..63; L[0]=2, L[63]=127.
  - Magnitude m = L[i] for q = 0 or 2; m = L[63-i] for q = 1 or 3.
  - Sample value = 128+m for q = 0 or 1; 128-m for q = 2 or 3. The range is 1..255 and never wraps.
- States:
  - IDLE: phase held at 0, SAMPLE=128, no SAMPLE_VALID pulses. NOTE_ON with NOTE<48 latches inc(NOTE) and moves to PLAY. NOTE_ON with NOTE>=48 is ignored. NOTE_OFF is ignored.
  - PLAY: on each tick, SAMPLE <= sine(phase) and phase <= phase+inc (mod 2^PHASE_W). SAMPLE and SAMPLE_VALID are registered, so both appear in the cycle after the tick.
    - NOTE_ON with a valid NOTE latches the new inc; phase continues without reset (legato retrigger).
    - Invalid NOTE is ignored.
    - NOTE_OFF moves to RELEASE.
  - RELEASE: steps exactly as in PLAY. On a tick where phase+inc carries out of PHASE_W bits:
    - that tick's sample is still emitted;
    - phase <= 0 and the state moves to IDLE;
    - on the next cycle SAMPLE <= 128 without a SAMPLE_VALID pulse.
    - A valid NOTE_ON moves back to PLAY with the new inc and continuous phase.
- Simultaneous NOTE_ON and NOTE_OFF in the same cycle: NOTE_ON wins; NOTE_OFF is discarded.
- A note event arriving in the same cycle as a tick: the tick uses the old inc; the new inc applies from the next tick.
- The first tick after entering PLAY from IDLE emits sine(0) = 130.
- Reset asserted mid-note forces all reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset, then 1000 idle cycles -> SAMPLE=128, ACTIVE=0, SAMPLE_VALID never asserted.
- NOTE=33, NOTE_ON pulse -> ACTIVE=1 next cycle; first SAMPLE_VALID carries 130; pulses exactly every 256 clocks; phase advances 738 per tick; the carry-out period is 88 or 89 ticks.
- Play NOTE=33 for 2000 samples and log all SAMPLE values -> min >= 1, max <= 255, peak 255 near phase 0x4000, trough 1 near 0xC000; matches a reference model sample-by-sample.
- NOTE_OFF mid-cycle in PLAY -> samples continue until phase wrap, then IDLE; SAMPLE=128, ACTIVE=0, no further valid pulses.
- NOTE=47 retrigger while playing NOTE=0 -> step changes from 110 to 1657 at the next tick with no phase discontinuity. NOTE=50 NOTE_ON -> ignored. NOTE_ON and NOTE_OFF in the same cycle -> stays in PLAY.
- RST_N low for 3 cycles mid-note, asserted asynchronously between edges -> outputs go to reset values immediately; normal operation resumes after release.

Source files
------------

// File: rtl/note_sine_gen.sv
// Purpose: note index + on/off strobes -> 8-bit offset-binary sine stream (phase accumulator, quarter-wave LUT).
// Latency: SAMPLE/SAMPLE_VALID are registered and appear one clock after the internal sample tick.
// Backpressure: none; strobes are taken as they come and the sample pulse cannot be stalled.
module note_sine_gen #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int SAMPLE_DIV = 256,
  parameter int PHASE_W    = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [5:0] NOTE,
  input  logic       NOTE_ON,
  input  logic       NOTE_OFF,
  output logic [7:0] SAMPLE,
  output logic       SAMPLE_VALID,
  output logic       ACTIVE
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_RELEASE
  } state_t;

  // Phase increment for note n (0 = C2). Top-octave frequencies are kept in
  // millihertz and divided down by octave, so the whole derivation is
  // integer-only and evaluated once at elaboration.
  function automatic logic [PHASE_W-1:0] calc_inc(input int n);
    longint f5_mhz;
    longint num;
    longint den;
    int     oct;
    case (n % 12)
      0:       f5_mhz = 523251;
      1:       f5_mhz = 554365;
      2:       f5_mhz = 587330;
      3:       f5_mhz = 622254;
      4:       f5_mhz = 659255;
      5:       f5_mhz = 698456;
      6:       f5_mhz = 739989;
      7:       f5_mhz = 783991;
      8:       f5_mhz = 830609;
      9:       f5_mhz = 880000;
      10:      f5_mhz = 932328;
      11:      f5_mhz = 987767;
      default: f5_mhz = 0;
    endcase
    oct = (n / 12 > 3) ? 3 : n / 12;
    num = f5_mhz * (longint'(1) << PHASE_W) * longint'(SAMPLE_DIV);
    den = (longint'(CLK_HZ) * longint'(1000)) << (3 - oct);
    return PHASE_W'((num + den / 2) / den);
  endfunction

  // First quadrant of the sine, sampled at bin centres so the four
  // quadrants mirror without a repeated point: round(127*sin(pi/2*(k+0.5)/64)).
  function automatic logic [6:0] qw_lut(input logic [5:0] k);
    logic [6:0] v;
    case (k)
      6'd0:  v = 7'd2;    6'd1:  v = 7'd5;    6'd2:  v = 7'd8;    6'd3:  v = 7'd11;
      6'd4:  v = 7'd14;   6'd5:  v = 7'd17;   6'd6:  v = 7'd20;   6'd7:  v = 7'd23;
      6'd8:  v = 7'd26;   6'd9:  v = 7'd29;   6'd10: v = 7'd32;   6'd11: v = 7'd35;
      6'd12: v = 7'd38;   6'd13: v = 7'd41;   6'd14: v = 7'd44;   6'd15: v = 7'd47;
      6'd16: v = 7'd50;   6'd17: v = 7'd53;   6'd18: v = 7'd56;   6'd19: v = 7'd58;
      6'd20: v = 7'd61;   6'd21: v = 7'd64;   6'd22: v = 7'd67;   6'd23: v = 7'd69;
      6'd24: v = 7'd72;   6'd25: v = 7'd74;   6'd26: v = 7'd77;   6'd27: v = 7'd79;
      6'd28: v = 7'd82;   6'd29: v = 7'd84;   6'd30: v = 7'd86;   6'd31: v = 7'd89;
      6'd32: v = 7'd91;   6'd33: v = 7'd93;   6'd34: v = 7'd95;   6'd35: v = 7'd97;
      6'd36: v = 7'd99;   6'd37: v = 7'd101;  6'd38: v = 7'd103;  6'd39: v = 7'd105;
      6'd40: v = 7'd106;  6'd41: v = 7'd108;  6'd42: v = 7'd110;  6'd43: v = 7'd111;
      6'd44: v = 7'd113;  6'd45: v = 7'd114;  6'd46: v = 7'd115;  6'd47: v = 7'd117;
      6'd48: v = 7'd118;  6'd49: v = 7'd119;  6'd50: v = 7'd120;  6'd51: v = 7'd121;
      6'd52: v = 7'd122;  6'd53: v = 7'd123;  6'd54: v = 7'd124;  6'd55: v = 7'd124;
      6'd56: v = 7'd125;  6'd57: v = 7'd125;  6'd58: v = 7'd126;  6'd59: v = 7'd126;
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  // Increment ROM; entries 48..63 are unreachable because invalid notes are never latched.
  logic [PHASE_W-1:0] inc_rom [64];
  for (genvar g = 0; g < 64; g++) begin : g_inc_rom
    localparam logic [PHASE_W-1:0] INC_V = (g < 48) ? calc_inc(g) : '0;
    assign inc_rom[g] = INC_V;
  end

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_nxt;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W-1:0] inc_nxt;
  logic [PHASE_W-1:0] phase_sum;
  logic               carry;
  logic [7:0]         phase_top;
  logic [5:0]         lut_idx;
  logic [6:0]         mag;
  logic [7:0]         sine_val;
  logic [7:0]         sample_nxt;
  logic               vld_nxt;
  logic               on_evt;
  logic               off_evt;

  assign tick      = (tick_cnt == CNT_LAST);
  assign on_evt    = NOTE_ON & (NOTE < 6'd48);
  // A release only counts when no note-on shares the cycle.
  assign off_evt   = NOTE_OFF & ~NOTE_ON;
  assign {carry, phase_sum} = {1'b0, phase} + {1'b0, inc};
  assign phase_top = phase[PHASE_W-1 -: 8];
  assign ACTIVE    = (state != ST_IDLE);

  // Free-running sample-rate divider; note events never touch it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Fold the phase onto the quarter-wave table and apply the half-wave sign.
  always_comb begin
    lut_idx  = phase_top[6] ? ~phase_top[5:0] : phase_top[5:0];
    mag      = qw_lut(lut_idx);
    sine_val = phase_top[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
  end

  // Next state, phase, increment and sample; a tick always uses the increment already latched.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    inc_nxt    = inc;
    sample_nxt = SAMPLE;
    vld_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        phase_nxt  = '0;
        sample_nxt = 8'd128;
        if (on_evt) begin
          inc_nxt   = inc_rom[NOTE];
          state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          sample_nxt = sine_val;
          vld_nxt    = 1'b1;
          phase_nxt  = phase_sum;
        end
        if (on_evt) begin
          inc_nxt = inc_rom[NOTE];
        end else if (off_evt) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (tick) begin
          sample_nxt = sine_val;
          vld_nxt    = 1'b1;
          phase_nxt  = phase_sum;
          // Stop at the end of the cycle unless a new note-on keeps it going.
          if (carry && !on_evt) begin
            phase_nxt = '0;
            state_nxt = ST_IDLE;
          end
        end
        if (on_evt) begin
          inc_nxt   = inc_rom[NOTE];
          state_nxt = ST_PLAY;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      phase        <= '0;
      inc          <= '0;
      SAMPLE       <= 8'd128;
      SAMPLE_VALID <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      inc          <= inc_nxt;
      SAMPLE       <= sample_nxt;
      SAMPLE_VALID <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_note_sine_gen.sv
module tb_note_sine_gen;

  // Sample rate shortened; CLK_HZ scaled so the increments equal the 10 MHz / 256 defaults.
  localparam int  CLK_HZ = 1_250_000;
  localparam int  DIV    = 32;
  localparam int  PW     = 16;
  localparam int  PH_MOD = 1 << PW;
  localparam real PI     = 3.14159265358979;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [5:0] NOTE = 6'd0;
  logic       NOTE_ON = 1'b0;
  logic       NOTE_OFF = 1'b0;
  logic [7:0] SAMPLE;
  logic       SAMPLE_VALID;
  logic       ACTIVE;

  note_sine_gen #(.CLK_HZ(CLK_HZ), .SAMPLE_DIV(DIV), .PHASE_W(PW)) dut (
    .CLK(CLK), .RST_N(RST_N), .NOTE(NOTE), .NOTE_ON(NOTE_ON), .NOTE_OFF(NOTE_OFF),
    .SAMPLE(SAMPLE), .SAMPLE_VALID(SAMPLE_VALID), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: musical pitch, ideal sine, tone on/off bookkeeping.
  int m_cnt, m_phase, m_inc, exp_sample;
  bit m_play, m_rel, exp_vld;

  function automatic int ref_inc(input int n);
    real f;
    f = 440.0 * (2.0 ** ((real'(n) - 33.0) / 12.0));
    return $rtoi(f * real'(PH_MOD) * real'(DIV) / real'(CLK_HZ) + 0.5);
  endfunction

  function automatic int ref_sine(input int ph);
    real s, a;
    int  m;
    s = $sin(2.0 * PI * (real'(ph >> (PW - 8)) + 0.5) / 256.0);
    a = (s < 0.0) ? -s : s;
    m = $rtoi(127.0 * a + 0.5);
    return (s >= 0.0) ? 128 + m : 128 - m;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_inc = 0; m_play = 0; m_rel = 0;
    exp_sample = 128; exp_vld = 0;
  endtask

  // What one rising edge does to the tone given the strobes present at it.
  task automatic model_edge(input bit on, input bit off, input logic [5:0] nt);
    bit tick, valid_on, was_playing;
    int nxt;
    tick        = (m_cnt == DIV - 1);
    m_cnt       = (m_cnt + 1) % DIV;
    valid_on    = on && (nt < 48);
    was_playing = m_play;
    exp_vld     = 0;
    if (!was_playing) begin
      exp_sample = 128;
    end else if (tick) begin
      exp_sample = ref_sine(m_phase);
      exp_vld    = 1;
      nxt        = m_phase + m_inc;
      if (m_rel && nxt >= PH_MOD && !valid_on) begin
        m_play = 0; m_rel = 0; m_phase = 0;
      end else begin
        m_phase = nxt % PH_MOD;
      end
    end
    if (valid_on) begin
      m_inc = ref_inc(int'(nt)); m_play = 1; m_rel = 0;
    end else if (off && !on && m_play) begin
      m_rel = 1;
    end
  endtask

  // One clock with the given strobes, then compare all outputs on the falling edge.
  task automatic cyc(input bit on, input bit off, input logic [5:0] nt);
    NOTE = nt; NOTE_ON = on; NOTE_OFF = off;
    model_edge(on, off, nt);
    @(posedge CLK);
    @(negedge CLK);
    NOTE_ON = 1'b0; NOTE_OFF = 1'b0;
    check("sample", 32'(SAMPLE), 32'(exp_sample));
    check("sample_valid", 32'(SAMPLE_VALID), 32'(exp_vld));
    check("active", 32'(ACTIVE), 32'(m_play));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    int seen, last, smin, smax, rel_cnt, r;

    // Reset state.
    model_reset();
    @(negedge CLK);
    check("reset_sample", 32'(SAMPLE), 32'd128);
    check("reset_valid", 32'(SAMPLE_VALID), 32'd0);
    check("reset_active", 32'(ACTIVE), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Long idle with stray note-off and an out-of-range note-on.
    idle_cycles(500);
    cyc(1'b0, 1'b1, 6'd0);
    cyc(1'b1, 1'b0, 6'd50);
    idle_cycles(500);

    // A4 from silence: first sample 130, fixed period, full swing.
    cyc(1'b1, 1'b0, 6'd33);
    check("a4_active", 32'(ACTIVE), 32'd1);
    seen = 0; last = -1; smin = 999; smax = -1;
    for (int c = 0; c < 601 * DIV && seen < 600; c++) begin
      cyc(1'b0, 1'b0, 6'd0);
      if (SAMPLE_VALID === 1'b1) begin
        if (seen == 0) check("first_sample", 32'(SAMPLE), 32'd130);
        else           check("valid_period", 32'(c - last), 32'(DIV));
        last = c;
        seen++;
        if (int'(SAMPLE) < smin) smin = int'(SAMPLE);
        if (int'(SAMPLE) > smax) smax = int'(SAMPLE);
      end
    end
    check("a4_sample_count", 32'(seen), 32'd600);
    check("a4_min", 32'(smin), 32'd1);
    check("a4_max", 32'(smax), 32'd255);

    // Release mid-cycle: finishes the wave, then parks at 128.
    for (int c = 0; c < 7 * DIV; c++) cyc(1'b0, 1'b0, 6'd0);
    rel_cnt = 0;
    cyc(1'b0, 1'b1, 6'd0);
    if (SAMPLE_VALID === 1'b1) rel_cnt++;
    for (int c = 0; c < 100 * DIV && ACTIVE === 1'b1; c++) begin
      cyc(1'b0, 1'b0, 6'd0);
      if (SAMPLE_VALID === 1'b1) rel_cnt++;
    end
    check("release_done", 32'(ACTIVE), 32'd0);
    check("release_len_ok", 32'(rel_cnt >= 1 && rel_cnt <= 89), 32'd1);
    idle_cycles(3 * DIV);

    // C2, then B5 retrigger landing exactly on a tick edge.
    cyc(1'b1, 1'b0, 6'd0);
    idle_cycles(20 * DIV + 7);
    for (int c = 0; c < DIV && m_cnt != DIV - 1; c++) cyc(1'b0, 1'b0, 6'd0);
    cyc(1'b1, 1'b0, 6'd47);
    idle_cycles(12 * DIV);
    cyc(1'b1, 1'b0, 6'd50);
    idle_cycles(4 * DIV);
    cyc(1'b1, 1'b1, 6'd20);
    check("on_off_same_cycle_active", 32'(ACTIVE), 32'd1);
    idle_cycles(6 * DIV);
    check("on_wins_still_active", 32'(ACTIVE), 32'd1);

    // Asynchronous reset mid-note, between clock edges.
    for (int c = 0; c < 2 * DIV && SAMPLE_VALID !== 1'b1; c++) cyc(1'b0, 1'b0, 6'd0);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_sample", 32'(SAMPLE), 32'd128);
    check("async_rst_valid", 32'(SAMPLE_VALID), 32'd0);
    check("async_rst_active", 32'(ACTIVE), 32'd0);
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      check("rst_hold_sample", 32'(SAMPLE), 32'd128);
      check("rst_hold_active", 32'(ACTIVE), 32'd0);
    end
    RST_N = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 6'd33);
    idle_cycles(5 * DIV);

    // Random note traffic, including invalid notes and collisions.
    for (int k = 0; k < 40; k++) begin
      idle_cycles(int'($urandom_range(1, 150)));
      r = int'($urandom_range(0, 9));
      if (r <= 4)      cyc(1'b1, 1'b0, 6'($urandom_range(0, 63)));
      else if (r <= 7) cyc(1'b0, 1'b1, 6'd0);
      else if (r == 8) cyc(1'b1, 1'b1, 6'($urandom_range(0, 63)));
    end
    cyc(1'b0, 1'b1, 6'd0);
    for (int c = 0; c < 600 * DIV && ACTIVE === 1'b1; c++) cyc(1'b0, 1'b0, 6'd0);
    check("final_idle", 32'(ACTIVE), 32'd0);
    idle_cycles(2 * DIV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
